// File: rtl/frame_encode.sv
// -----------------------------------------------------------------------------
// frame_encode
// Turns one register-write command into one SPI frame. The frame is the
// address byte, the low data byte, then the high data byte, all sent while
// spi_ss is held low. Bytes go to an external byte shifter over a
// valid/ready handshake.
//
// Optional build macro: FRAME_ENCODE_CHECKSUM_EN
//   When defined, a fourth byte is appended:
//   cmd_addr ^ cmd_data[7:0] ^ cmd_data[15:8].
//
// Parameters
//   SETUP_CYCLES : cycles spi_ss is low before the first byte is offered (1..255)
//   GAP_CYCLES   : cycles spi_ss is high after a frame before the next command (1..255)
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   cmd_addr/cmd_data : command payload, latched when the command is accepted
//   cmd_valid/ready   : command handshake; cmd_ready is high only in IDLE
//   tx_data/valid     : byte offered to the shifter
//   tx_ready          : shifter takes tx_data this cycle
//   tx_busy           : shifter is still shifting out a byte
//   spi_ss            : active-low slave select
//   frame_done        : one-cycle pulse when the frame ends
//   busy              : high whenever the encoder is not idle
// -----------------------------------------------------------------------------
module frame_encode #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_busy,
    output logic        spi_ss,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 16;

`ifdef FRAME_ENCODE_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_DRAIN,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                spi_ss_q, spi_ss_d;
    logic                frame_done_q, frame_done_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;

    // Byte of the latched frame at a given position.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] a,
        input logic [DATA_W-1:0] d
    );
        logic [BYTE_W-1:0] b;
        b = '0;
        case (idx)
            IDX_W'(0): b = a;
            IDX_W'(1): b = d[7:0];
            IDX_W'(2): b = d[15:8];
`ifdef FRAME_ENCODE_CHECKSUM_EN
            IDX_W'(3): b = a ^ d[7:0] ^ d[15:8];
`endif
            default:   b = '0;
        endcase
        return b;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        spi_ss_d     = spi_ss_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d   = cmd_addr;
                    data_d   = cmd_data;
                    spi_ss_d = 1'b0;
                    cnt_d    = CNT_W'(SETUP_CYCLES);
                    idx_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter reaches zero on this edge: first byte goes out.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d      = '0;
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_byte(idx_q, addr_q, data_q);
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_DRAIN;
                    end else begin
                        tx_data_d = frame_byte(idx_d, addr_q, data_q);
                    end
                end
            end
            ST_DRAIN: begin
                // Hold the select low until the shifter has emptied.
                if (!tx_busy) begin
                    spi_ss_d     = 1'b1;
                    frame_done_d = 1'b1;
                    cnt_d        = CNT_W'(GAP_CYCLES);
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            spi_ss_q     <= 1'b1;
            frame_done_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            spi_ss_q     <= spi_ss_d;
            frame_done_q <= frame_done_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign spi_ss     = spi_ss_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_encode.sv
// -----------------------------------------------------------------------------
// tb_frame_encode
// Directed bench for frame_encode with default parameters
// (SETUP_CYCLES=2, GAP_CYCLES=4). Cycle numbers below count clock edges
// after the edge that accepts the command (cycle 0 = right after that edge).
// -----------------------------------------------------------------------------
module tb_frame_encode;

`ifdef FRAME_ENCODE_CHECKSUM_EN
    localparam int FRAME_N = 4;
`else
    localparam int FRAME_N = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_busy;
    logic        spi_ss;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_frame.
    logic [7:0] got [4];
    logic [7:0] stall_val;
    int  nb, first_valid, done_cyc, done_cnt, ss_rise, ready_cyc, last_acc_cyc;
    int  stall_bad, ss_bad;
    bit  timeout;
    bit  issue_ok;

    frame_encode #(
        .SETUP_CYCLES(2),
        .GAP_CYCLES  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .spi_ss    (spi_ss),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for cmd_ready, present a command for one edge.
    task automatic issue(input logic [7:0] a, input logic [15:0] d, input bit keep_valid);
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            tick();
        end
        issue_ok  = cmd_ready;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    // Play the shifter side of one frame, starting at cycle 0, until cmd_ready returns.
    task automatic run_frame(input int stall_idx, input int stall_len, input int busy_len,
                             input bit idle_ready);
        int stall_cnt = 0;
        int busy_rem  = 0;
        nb = 0; first_valid = -1; done_cyc = -1; done_cnt = 0; ss_rise = -1;
        ready_cyc = -1; last_acc_cyc = -1; stall_bad = 0; ss_bad = 0; timeout = 1'b1;
        stall_val = 8'h00;
        for (int k = 0; k < 4; k++) got[k] = 8'h00;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cmd_ready) begin
                ready_cyc = cyc;
                timeout   = 1'b0;
                break;
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (spi_ss && ss_rise < 0) ss_rise = cyc;
            if (tx_valid && spi_ss) ss_bad++;
            tx_ready = idle_ready;
            tx_busy  = 1'b0;
            if (busy_rem > 0) begin
                tx_busy = 1'b1;
                busy_rem--;
            end
            if (tx_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (nb == stall_idx && stall_cnt < stall_len) begin
                    tx_ready = 1'b0;
                    if (stall_cnt == 0) stall_val = tx_data;
                    else if (tx_data !== stall_val) stall_bad++;
                    stall_cnt++;
                end else begin
                    if (nb == stall_idx && stall_cnt > 0 && tx_data !== stall_val) stall_bad++;
                    tx_ready = 1'b1;
                    if (nb < 4) got[nb] = tx_data;
                    nb++;
                    if (nb == FRAME_N) begin
                        busy_rem     = busy_len;
                        last_acc_cyc = cyc;
                    end
                end
            end
            tick();
        end
        tx_ready = 1'b0;
        tx_busy  = 1'b0;
        if (timeout) $display("FAIL run_frame_timeout: cmd_ready not seen within 200 cycles");
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 8'h33; cmd_data = 16'h4455;
        tx_ready = 1'b0; tx_busy = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({spi_ss, tx_valid, tx_data, cmd_ready, frame_done, busy} !== 13'b1_0_00000000_0_0_0) begin
            errors++;
            $display("FAIL reset_outputs: ss=%b tv=%b td=%h rdy=%b done=%b busy=%b, want 1 0 00 0 0 0",
                     spi_ss, tx_valid, tx_data, cmd_ready, frame_done, busy);
        end
        rst = 1'b0;
        tick();
        cmd_valid = 1'b0;
        // cmd_valid was high at the release edge but cmd_ready was still 0.
        checks++;
        if ({cmd_ready, busy, spi_ss} !== 3'b101) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b ss=%b, want 1 0 1", cmd_ready, busy, spi_ss);
        end
    endtask

    task automatic test_basic();
        issue(8'h12, 16'hABCD, 1'b0);
        checks++;
        if (issue_ok !== 1'b1) begin
            errors++; $display("FAIL basic_ready: got %b want 1", issue_ok);
        end
        checks++;
        if ({busy, spi_ss, cmd_ready, tx_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_accept: busy=%b ss=%b rdy=%b tv=%b, want 1 0 0 0", busy, spi_ss, cmd_ready, tx_valid);
        end
        run_frame(-1, 0, 0, 1'b1);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", timeout); end
        checks++;
        if (nb !== FRAME_N) begin errors++; $display("FAIL basic_nbytes: got %0d want %0d", nb, FRAME_N); end
        checks++;
        if ({got[0], got[1], got[2]} !== 24'h12CDAB) begin
            errors++; $display("FAIL basic_bytes: got %h %h %h want 12 cd ab", got[0], got[1], got[2]);
        end
        checks++;
        if (first_valid !== 2) begin errors++; $display("FAIL basic_setup: first tx_valid at %0d want 2", first_valid); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (done_cyc !== 6 + (FRAME_N - 3) || ss_rise !== done_cyc) begin
            errors++; $display("FAIL basic_done_cycle: done=%0d ss_rise=%0d want %0d", done_cyc, ss_rise, 6 + (FRAME_N - 3));
        end
        checks++;
        if (ready_cyc - done_cyc !== 4) begin
            errors++; $display("FAIL basic_gap: cmd_ready %0d cycles after done, want 4", ready_cyc - done_cyc);
        end
        checks++;
        if (ss_bad !== 0) begin errors++; $display("FAIL basic_ss_low: %0d valid cycles with ss high, want 0", ss_bad); end
    endtask

    task automatic test_stall();
        issue(8'h12, 16'hABCD, 1'b0);
        run_frame(1, 10, 0, 1'b0);
        checks++;
        if (stall_val !== 8'hCD || stall_bad !== 0) begin
            errors++; $display("FAIL stall_hold: held %h with %0d changes, want cd and 0", stall_val, stall_bad);
        end
        checks++;
        if (ss_bad !== 0 || ss_rise !== done_cyc) begin
            errors++; $display("FAIL stall_ss: bad=%0d rise=%0d done=%0d", ss_bad, ss_rise, done_cyc);
        end
        checks++;
        if ({got[0], got[1], got[2]} !== 24'h12CDAB || nb !== FRAME_N) begin
            errors++; $display("FAIL stall_bytes: got %h %h %h n=%0d want 12 cd ab", got[0], got[1], got[2], nb);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 16 + (FRAME_N - 3) || timeout !== 1'b0) begin
            errors++; $display("FAIL stall_done: cnt=%0d cyc=%0d want 1 and %0d", done_cnt, done_cyc, 16 + (FRAME_N - 3));
        end
    endtask

    task automatic test_drain_busy();
        issue(8'h12, 16'hABCD, 1'b0);
        run_frame(-1, 0, 5, 1'b0);
        checks++;
        if (last_acc_cyc !== 4 + (FRAME_N - 3)) begin
            errors++; $display("FAIL drain_last_accept: got %0d want %0d", last_acc_cyc, 4 + (FRAME_N - 3));
        end
        // busy high on the 5 cycles after the last accept, low on the 6th; ss rises one edge later.
        checks++;
        if (ss_rise !== 11 + (FRAME_N - 3) || done_cyc !== ss_rise || done_cnt !== 1) begin
            errors++; $display("FAIL drain_ss_rise: rise=%0d done=%0d cnt=%0d want %0d", ss_rise, done_cyc, done_cnt, 11 + (FRAME_N - 3));
        end
    endtask

    task automatic test_reset_midframe();
        int dones = 0;
        issue(8'h12, 16'hABCD, 1'b0);
        tx_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({tx_valid, tx_data, spi_ss} !== 10'b1_00010010_0) begin
            errors++; $display("FAIL midrst_byte1: tv=%b td=%h ss=%b want 1 12 0", tx_valid, tx_data, spi_ss);
        end
        rst = 1'b1;
        tick();
        if (frame_done) dones++;
        checks++;
        if ({spi_ss, tx_valid, busy, cmd_ready} !== 4'b1000) begin
            errors++; $display("FAIL midrst_abort: ss=%b tv=%b busy=%b rdy=%b want 1 0 0 0", spi_ss, tx_valid, busy, cmd_ready);
        end
        tick();
        if (frame_done) dones++;
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        for (int i = 0; i < 6; i++) begin
            if (frame_done) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
        issue(8'h5A, 16'h1234, 1'b0);
        run_frame(-1, 0, 0, 1'b1);
        checks++;
        if ({got[0], got[1], got[2]} !== 24'h5A3412 || done_cnt !== 1 || timeout !== 1'b0) begin
            errors++; $display("FAIL midrst_new_frame: got %h %h %h done=%0d want 5a 34 12 1", got[0], got[1], got[2], done_cnt);
        end
    endtask

    task automatic test_hold_cmd();
        // cmd_valid stays high with new payload for the whole frame, including the frame_done cycle.
        issue(8'h12, 16'hABCD, 1'b1);
        cmd_addr = 8'hFF;
        cmd_data = 16'h0000;
        run_frame(-1, 0, 0, 1'b1);
        cmd_valid = 1'b0;
        checks++;
        if ({got[0], got[1], got[2]} !== 24'h12CDAB) begin
            errors++; $display("FAIL hold_bytes: got %h %h %h want 12 cd ab", got[0], got[1], got[2]);
        end
        checks++;
        if (done_cnt !== 1 || ready_cyc - done_cyc !== 4 || timeout !== 1'b0) begin
            errors++; $display("FAIL hold_gap: done=%0d ready-done=%0d want 1 and 4", done_cnt, ready_cyc - done_cyc);
        end
        tick();
        checks++;
        if ({busy, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL hold_idle: busy=%b rdy=%b want 0 1", busy, cmd_ready);
        end
    endtask

`ifdef FRAME_ENCODE_CHECKSUM_EN
    task automatic test_checksum();
        issue(8'h12, 16'hABCD, 1'b0);
        run_frame(-1, 0, 0, 1'b1);
        checks++;
        if (nb !== 4 || got[3] !== 8'h74) begin
            errors++; $display("FAIL checksum_byte: n=%0d byte3=%h want 4 and 74", nb, got[3]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drain_busy();
        test_reset_midframe();
        test_hold_cmd();
`ifdef FRAME_ENCODE_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_encode.md
FRAME_ENCODE -- requirements
Module: frame_encode

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: clk cycles spi_ss is held low before the first byte is offered (legal range 1..255).
REQ-002 Parameter GAP_CYCLES, default 4: clk cycles spi_ss is held high after a frame before a new command is accepted (legal range 1..255).
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cmd_addr  input  8  register address of the command.
REQ-006 cmd_data  input  16  register write data of the command.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  encoder can accept a command.
REQ-009 tx_data  output  8  byte offered to the SPI byte shifter.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  shifter accepts tx_data this cycle.
REQ-012 tx_busy  input  1  shifter is still shifting a byte.
REQ-013 spi_ss  output  1  active-low slave select for the frame.
REQ-014 frame_done  output  1  single-cycle pulse at frame end.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The frame SHALL consist of cmd_addr, then cmd_data[7:0], then cmd_data[15:8], all inside one spi_ss low window.
REQ-017 The states SHALL be IDLE, SETUP, SEND, DRAIN and GAP.
REQ-018 cmd_ready SHALL equal 1 only in IDLE, and a command SHALL be accepted when cmd_valid and cmd_ready are both 1.
REQ-019 On acceptance, the address and data SHALL be latched, spi_ss SHALL go 0 at the same edge, the down-counter SHALL load SETUP_CYCLES, and the state SHALL go to SETUP.
REQ-020 In SETUP, the counter SHALL decrement each cycle, and the state SHALL go to SEND on the edge at which it reaches 0, so tx_valid first rises exactly SETUP_CYCLES cycles after spi_ss falls.
REQ-021 In SEND, tx_valid SHALL be 1 and tx_data SHALL be the byte selected by a 2-bit byte index; tx_data SHALL stay stable until tx_valid and tx_ready are both 1.
REQ-022 On each accepted byte, the byte index SHALL advance; when the last byte is accepted, tx_valid SHALL drop at that edge and the state SHALL go to DRAIN.
REQ-023 DRAIN SHALL last at least one cycle, and SHALL exit on the first cycle in which tx_busy is 0, asserting spi_ss=1 and frame_done=1 for one cycle, loading GAP_CYCLES, and going to GAP.
REQ-024 In GAP, the counter SHALL decrement, and the state SHALL return to IDLE on the edge at which it reaches 0, with cmd_ready=1 from the next cycle.
REQ-025 Changes on cmd_addr, cmd_data or cmd_valid after acceptance SHALL have no effect on the frame in flight.
REQ-026 A tx_ready input that is 1 while tx_valid is 0 SHALL be ignored.
REQ-027 tx_ready held at 0 SHALL stall SEND indefinitely, with spi_ss held at 0 and no timeout.
REQ-028 A cmd_valid input that is 1 on the same cycle as frame_done SHALL NOT be accepted, because cmd_ready is 0 in GAP.

Reset
REQ-029 While rst=1, the outputs SHALL be: spi_ss=1, tx_valid=0, tx_data=0x00, cmd_ready=0, frame_done=0 and busy=0, with the state IDLE, the counters 0 and the byte index 0.
REQ-030 cmd_ready SHALL rise on the first cycle after rst is released.
REQ-031 A reset asserted mid-frame SHALL raise spi_ss and drop tx_valid at the same edge, and SHALL discard the latched command without producing a frame_done pulse.

Configuration
REQ-032 When the macro FRAME_ENCODE_CHECKSUM_EN is defined, a 4th byte SHALL be appended as the last byte of the frame, equal to cmd_addr ^ cmd_data[7:0] ^ cmd_data[15:8], and REQ-022 SHALL then apply after 4 bytes.
REQ-033 When FRAME_ENCODE_CHECKSUM_EN is not defined, frames SHALL be exactly 3 bytes, and no checksum logic SHALL be present.

Verification
REQ-034 The bench SHALL cover: addr=0x12, data=0xABCD, tx_ready tied to 1, tx_busy=0 -> bytes 0x12, 0xCD, 0xAB; spi_ss low 2 cycles before the first tx_valid; one frame_done pulse; cmd_ready back 4 cycles after frame_done.
REQ-035 The bench SHALL cover: tx_ready held 0 for 10 cycles on byte 2 -> tx_data held at 0xCD and spi_ss held at 0 throughout; the frame completes normally.
REQ-036 The bench SHALL cover: tx_busy held 1 for 5 cycles after the last accept -> spi_ss rises on the first cycle tx_busy is 0.
REQ-037 The bench SHALL cover: rst pulsed during byte 1 -> spi_ss=1 and tx_valid=0 next cycle, no frame_done, and a new command is accepted after release.
REQ-038 The bench SHALL cover: cmd_data changed to 0x0000 after acceptance -> the original 0xABCD bytes are still sent.
REQ-039 The bench SHALL cover, with FRAME_ENCODE_CHECKSUM_EN: addr=0x12, data=0xABCD -> 4th byte is 0x74.
